// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, ALU operation codes, operand-source selects.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_LUI   = 4'b0111,
        ALU_AUIPC = 4'b1000,
        ALU_PASSB = 4'b1001,
        ALU_SLL   = 4'b1010,
        ALU_SRA   = 4'b1011,
        ALU_SRL   = 4'b1100
    } alu_op_e;

    localparam logic SRC_A_RS1 = 1'b0;
    localparam logic SRC_A_PC  = 1'b1;
    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand bypass for one source register: EX/MEM beats MEM/WB; x0 is never bypassed.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_ex_rs,
    input  logic [XLEN-1:0] i_reg_val,
    input  logic [RA_W-1:0] i_mem_rd,
    input  logic            i_mem_reg_write,
    input  logic [XLEN-1:0] i_mem_result,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic            i_wb_reg_write,
    input  logic [XLEN-1:0] i_wb_result,
    output logic [XLEN-1:0] o_val
);

    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_mem = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs);
    assign w_hit_wb  = i_wb_reg_write  && (i_wb_rd  != '0) && (i_wb_rd  == i_ex_rs);

    always_comb begin
        o_val = i_reg_val;
        if (w_hit_mem)
            o_val = i_mem_result;
        else if (w_hit_wb)
            o_val = i_wb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode, bypasses results into ALU operands,
// and inserts bubbles on load-use hazards and branch flushes.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RA_W = riscv_pkg::RA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [3:0]      id_con,
    input  logic            id_src_a,
    input  logic            id_src_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            flush,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_con,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            load_use_stall
);

    logic            r_valid_p1;
    logic [XLEN-1:0] r_pc_p1;
    logic [XLEN-1:0] r_rs1_data_p1;
    logic [XLEN-1:0] r_rs2_data_p1;
    logic [XLEN-1:0] r_imm_p1;
    logic [RA_W-1:0] r_rs1_p1;
    logic [RA_W-1:0] r_rs2_p1;
    logic [RA_W-1:0] r_rd_p1;
    logic [3:0]      r_con_p1;
    logic            r_src_a_p1;
    logic            r_src_b_p1;
    logic            r_reg_write_p1;
    logic            r_mem_read_p1;
    logic            r_mem_write_p1;

    logic            w_hazard;
    logic            w_stall;
    logic [XLEN-1:0] w_rs1_cap;
    logic [XLEN-1:0] w_rs2_cap;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // Load in EX whose rd is read by the instruction in ID: one bubble covers the load latency.
    assign w_hazard = r_valid_p1 && r_mem_read_p1 && (r_rd_p1 != '0) && id_valid &&
                      ((r_rd_p1 == id_rs1) || (r_rd_p1 == id_rs2));
    assign w_stall  = w_hazard && !flush;

    // The register file is read in the same cycle WB writes it, so the fresh value is picked up here.
    assign w_rs1_cap = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_result : id_rs1_data;
    assign w_rs2_cap = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_result : id_rs2_data;

    // ---- ID -> EX boundary (p0 -> p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_p1     <= 1'b0;
            r_pc_p1        <= '0;
            r_rs1_data_p1  <= '0;
            r_rs2_data_p1  <= '0;
            r_imm_p1       <= '0;
            r_rs1_p1       <= '0;
            r_rs2_p1       <= '0;
            r_rd_p1        <= '0;
            r_con_p1       <= ALU_ADD;
            r_src_a_p1     <= SRC_A_RS1;
            r_src_b_p1     <= SRC_B_RS2;
            r_reg_write_p1 <= 1'b0;
            r_mem_read_p1  <= 1'b0;
            r_mem_write_p1 <= 1'b0;
        end else if (flush || w_stall) begin
            r_valid_p1     <= 1'b0;
            r_rd_p1        <= '0;
            r_con_p1       <= ALU_ADD;
            r_reg_write_p1 <= 1'b0;
            r_mem_read_p1  <= 1'b0;
            r_mem_write_p1 <= 1'b0;
        end else begin
            r_valid_p1     <= id_valid;
            r_pc_p1        <= id_pc;
            r_rs1_data_p1  <= w_rs1_cap;
            r_rs2_data_p1  <= w_rs2_cap;
            r_imm_p1       <= id_imm;
            r_rs1_p1       <= id_rs1;
            r_rs2_p1       <= id_rs2;
            r_rd_p1        <= id_valid ? id_rd : '0;
            r_con_p1       <= id_valid ? id_con : ALU_ADD;
            r_src_a_p1     <= id_src_a;
            r_src_b_p1     <= id_src_b;
            r_reg_write_p1 <= id_valid && id_reg_write;
            r_mem_read_p1  <= id_valid && id_mem_read;
            r_mem_write_p1 <= id_valid && id_mem_write;
        end
    end

    // ---- EX operand bypass (p1, combinational) ----
    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .i_ex_rs         (r_rs1_p1),
        .i_reg_val       (r_rs1_data_p1),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_result    (mem_result),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_result     (wb_result),
        .o_val           (w_fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .i_ex_rs         (r_rs2_p1),
        .i_reg_val       (r_rs2_data_p1),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_result    (mem_result),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_result     (wb_result),
        .o_val           (w_fwd_rs2)
    );

    assign alu_a          = (r_src_a_p1 == SRC_A_PC)  ? r_pc_p1  : w_fwd_rs1;
    assign alu_b          = (r_src_b_p1 == SRC_B_IMM) ? r_imm_p1 : w_fwd_rs2;
    assign ex_store_data  = w_fwd_rs2;
    assign alu_con        = r_con_p1;
    assign ex_valid       = r_valid_p1;
    assign ex_pc          = r_pc_p1;
    assign ex_rd          = r_rd_p1;
    assign ex_reg_write   = r_reg_write_p1;
    assign ex_mem_read    = r_mem_read_p1;
    assign ex_mem_write   = r_mem_write_p1;
    assign load_use_stall = w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, bypass priority, x0 guard, load-use and flush bubbles.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_con;
    logic        id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]  alu_con;
    logic [4:0]  ex_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_con(id_con),
        .id_src_a(id_src_a), .id_src_b(id_src_b), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_con(alu_con),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_con = 0; id_src_a = 0; id_src_b = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic clear_fwd();
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic mrd, input logic mwr);
        clear_id();
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = ~mwr; id_mem_read = mrd; id_mem_write = mwr;
    endtask

    initial begin
        rst = 1; flush = 0;
        clear_id(); clear_fwd();

        // Reset
        tick(); tick();
        #2;
        chk("rst_ex_valid", {31'b0, ex_valid}, 0);
        chk("rst_alu_con", {28'b0, alu_con}, 0);
        chk("rst_reg_write", {31'b0, ex_reg_write}, 0);
        chk("rst_stall", {31'b0, load_use_stall}, 0);
        chk("rst_ex_rd", {27'b0, ex_rd}, 0);
        @(negedge clk); rst = 0;

        // EX/MEM forward with MEM/WB also matching
        load_instr(5, 6, 3, 0, 0); id_rs1_data = 32'h11; id_rs2_data = 32'h22;
        tick();
        clear_id();
        mem_reg_write = 1; mem_rd = 5; mem_result = 32'hDEAD;
        #1;
        chk("fwd_mem_a", alu_a, 32'hDEAD);
        chk("fwd_b_regval", alu_b, 32'h22);
        chk("cap_ex_valid", {31'b0, ex_valid}, 1);
        chk("cap_ex_rd", {27'b0, ex_rd}, 3);
        chk("cap_reg_write", {31'b0, ex_reg_write}, 1);
        wb_reg_write = 1; wb_rd = 5; wb_result = 32'hBEEF;
        #1;
        chk("fwd_mem_prio", alu_a, 32'hDEAD);
        mem_reg_write = 0;
        #1;
        chk("fwd_wb_a", alu_a, 32'hBEEF);
        clear_fwd();
        #1;
        chk("fwd_none_a", alu_a, 32'h11);

        // x0 guard
        load_instr(1, 0, 2, 0, 0); id_con = 4'b0001;
        tick();
        clear_id();
        mem_rd = 0; mem_reg_write = 1; mem_result = 32'h1234;
        wb_rd = 0; wb_reg_write = 1; wb_result = 32'h5678;
        #1;
        chk("x0_guard_b", alu_b, 0);
        chk("con_sub", {28'b0, alu_con}, 1);
        clear_fwd();

        // Capture-time WB bypass
        load_instr(9, 10, 2, 0, 0); id_rs1_data = 32'hAAAA; id_rs2_data = 32'hBBBB;
        wb_rd = 9; wb_reg_write = 1; wb_result = 32'h7777;
        tick();
        clear_id(); clear_fwd();
        #1;
        chk("wb_cap_a", alu_a, 32'h7777);
        chk("wb_cap_b", alu_b, 32'hBBBB);

        // Load-use: lw x7 in EX, dependent in ID
        load_instr(2, 0, 7, 1, 0); id_reg_write = 1;
        tick();
        load_instr(8, 7, 9, 0, 0); id_con = 4'b0100;
        #1;
        chk("lu_stall", {31'b0, load_use_stall}, 1);
        chk("lu_ex_mem_read", {31'b0, ex_mem_read}, 1);
        tick();
        chk("lu_bubble_valid", {31'b0, ex_valid}, 0);
        chk("lu_bubble_rw", {31'b0, ex_reg_write}, 0);
        chk("lu_bubble_con", {28'b0, alu_con}, 0);
        chk("lu_stall_once", {31'b0, load_use_stall}, 0);
        tick();
        clear_id();
        #1;
        chk("lu_held_valid", {31'b0, ex_valid}, 1);
        chk("lu_held_rd", {27'b0, ex_rd}, 9);
        chk("lu_held_con", {28'b0, alu_con}, 4);

        // Flush beats load-use
        load_instr(2, 0, 7, 1, 0); id_reg_write = 1;
        tick();
        load_instr(7, 3, 0, 0, 1);
        flush = 1;
        #1;
        chk("fl_no_stall", {31'b0, load_use_stall}, 0);
        tick();
        flush = 0; clear_id();
        #1;
        chk("fl_valid", {31'b0, ex_valid}, 0);
        chk("fl_mem_write", {31'b0, ex_mem_write}, 0);
        chk("fl_rd", {27'b0, ex_rd}, 0);

        // Immediate / PC select with forwarded store data
        load_instr(1, 4, 6, 0, 0);
        id_src_a = 1; id_pc = 32'h100; id_src_b = 1; id_imm = 32'hFFFFF800;
        id_rs1_data = 32'h9; id_rs2_data = 32'h0;
        tick();
        clear_id();
        mem_rd = 4; mem_reg_write = 1; mem_result = 32'h55;
        #1;
        chk("sel_alu_a_pc", alu_a, 32'h100);
        chk("sel_alu_b_imm", alu_b, 32'hFFFFF800);
        chk("sel_store_data", ex_store_data, 32'h55);
        chk("sel_ex_pc", ex_pc, 32'h100);
        clear_fwd();

        // id_valid=0 captured as a bubble with gated controls
        load_instr(1, 2, 5, 0, 1); id_valid = 0; id_reg_write = 1; id_con = 4'b0011;
        tick();
        clear_id();
        #1;
        chk("inv_valid", {31'b0, ex_valid}, 0);
        chk("inv_reg_write", {31'b0, ex_reg_write}, 0);
        chk("inv_mem_write", {31'b0, ex_mem_write}, 0);
        chk("inv_con", {28'b0, alu_con}, 0);

        // Reset during a stall
        load_instr(2, 0, 7, 1, 0); id_reg_write = 1;
        tick();
        load_instr(7, 0, 4, 0, 0);
        #1;
        chk("rs_stall_pre", {31'b0, load_use_stall}, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("rs_stall_clear", {31'b0, load_use_stall}, 0);
        chk("rs_valid", {31'b0, ex_valid}, 0);
        clear_id();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the RISC-V core, directly upstream of the ALU.
- Registers the decoded instruction and resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU operand and control inputs (A, B, 4-bit con).
- Detects load-use hazards and inserts bubbles; handles branch flush.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  decode holds a valid instruction
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  register file read data, rs1
id_rs2_data  in  XLEN  register file read data, rs2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  RA_W  rs1 address
id_rs2  in  RA_W  rs2 address
id_rd  in  RA_W  rd address
id_con  in  4  ALU operation code
id_src_a  in  1  0=rs1, 1=pc
id_src_b  in  1  0=rs2, 1=imm
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
id_mem_write  in  1  instruction is a store
flush  in  1  branch/jump redirect from EX
mem_rd  in  RA_W  EX/MEM destination
mem_reg_write  in  1  EX/MEM writes rd
mem_result  in  XLEN  EX/MEM ALU result
wb_rd  in  RA_W  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes rd
wb_result  in  XLEN  MEM/WB writeback value
ex_valid  out  1  EX holds a valid instruction
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
alu_con  out  4  ALU operation code
ex_store_data  out  XLEN  forwarded rs2, for stores
ex_pc  out  XLEN  registered PC
ex_rd  out  RA_W  registered rd
ex_reg_write  out  1  registered reg_write control
ex_mem_read  out  1  registered load control
ex_mem_write  out  1  registered store control
load_use_stall  out  1  freeze PC and IF/ID this cycle

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all registers 0, so ex_valid=0, alu_con=4'b0000 (ADD), ex_rd=0, all controls 0, PC/data/imm 0.
- Register update priority per edge: rst > flush > load_use_stall > normal capture.
- Normal capture: all id_* fields load into EX registers; latency is 1 cycle.
- Bubble (flush or stall):
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write <= 0.
  - ex_rd <= 0; alu_con <= ADD.
  - Data registers may hold any value.
- Load-use detection (combinational):
  - hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - load_use_stall = hazard & ~flush.
- Capture-time WB bypass: if wb_reg_write & wb_rd!=0 & wb_rd==id_rs1, capture wb_result instead of id_rs1_data. Same rule for rs2.
- Registered rs1/rs2 addresses are kept internally for forwarding.
- Operand forwarding (combinational, 0 latency, per operand):
  - If mem_reg_write & mem_rd!=0 & mem_rd==ex_rsN, select mem_result.
  - Else if wb_reg_write & wb_rd!=0 & wb_rd==ex_rsN, select wb_result.
  - Else select the registered value.
  - EX/MEM has priority over MEM/WB.
  - x0 is never forwarded.
- Operand selection:
  - alu_a = ex_src_a ? ex_pc : fwd_rs1.
  - alu_b = ex_src_b ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 regardless of src_b.
- Bubble outputs: alu_a/alu_b are don't-care when ex_valid=0. The downstream write enables are already 0.
- Flush and hazard in the same cycle: flush wins, no stall is asserted, and a bubble is inserted.
- Reset mid-stall: the stall clears the next cycle because ex_valid=0.
- id_valid=0 with no flush/stall: captured as a bubble (ex_valid=0), with controls gated by id_valid.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and RA_W.
  - ALU con encodings: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, LUI-style 0111–1001, SLL=1010, SRA=1011, SRL=1100.
  - SRC_A_RS1/PC and SRC_B_RS2/IMM constants.
- One sub-module, fwd_mux: priority forwarding select for one operand, instantiated twice (rs1, rs2).

Test Plan:
- Reset: rst=1 for 2 cycles → ex_valid=0, alu_con=0000, ex_reg_write=0, load_use_stall=0.
- EX/MEM forward:
  - Stimulus: capture add with rs1=5, id_rs1_data=0x11; next cycle mem_reg_write=1, mem_rd=5, mem_result=0xDEAD.
  - Required: alu_a=0xDEAD.
  - Also drive wb_rd=5, wb_result=0xBEEF → alu_a stays 0xDEAD.
- x0 guard: mem_rd=0, mem_reg_write=1, ex rs2=0, id_rs2_data=0 → alu_b=0, not mem_result.
- Load-use:
  - Stimulus: EX holds lw rd=7; ID has rs2=7, id_valid=1.
  - Required: load_use_stall=1 for exactly 1 cycle; next cycle ex_valid=0 and ex_reg_write=0.
  - The held instruction is captured the following cycle.
- Flush priority: same load-use condition plus flush=1 → load_use_stall=0; next cycle ex_valid=0, ex_mem_write=0.
- Immediate/PC select:
  - Stimulus: id_src_a=1, id_pc=0x100; id_src_b=1, id_imm=0xFFFFF800; rs2 forwarded 0x55.
  - Required: alu_a=0x100, alu_b=0xFFFFF800, ex_store_data=0x55.
